// File: rtl/data_mem_arb_pkg.sv
// Shared encodings for the data memory arbiter: access sizes, memi bit
// positions and the ownership state type.
package data_mem_arb_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    localparam int MEMI_UNS   = 4;
    localparam int MEMI_SZ_HI = 3;
    localparam int MEMI_SZ_LO = 2;
    localparam int MEMI_ST    = 1;
    localparam int MEMI_LD    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time
// is granted.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and DMA
// (port 1) with round-robin arbitration and a bounded burst lock.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_we,
    input  logic [1:0]  req0_size,
    input  logic        req0_uns,
    input  logic        req0_lock,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp0_err,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_we,
    input  logic [1:0]  req1_size,
    input  logic        req1_uns,
    input  logic        req1_lock,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic        rsp1_err,

    output logic [4:0]  mem_memi,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wren,
    input  logic [31:0] mem_rdata
);

    arb_state_t       state, state_nxt;
    logic             last_grant, last_nxt;
    logic [CNT_W-1:0] lock_cnt, cnt_nxt, cnt_inc;
    logic [1:0]       arb_gnt, gnt;
    logic             beat, sel, legal;
    logic             b_we, b_uns, b_lock;
    logic [1:0]       b_size;
    logic [31:0]      b_addr, b_wdata;
    logic [1:0]       rsp_v, rsp_e;
    logic [31:0]      rsp_d0, rsp_d1;

    rr_arb2 u_rr_arb2 (
        .req  ({req1_valid, req0_valid}),
        .last (last_grant),
        .gnt  (arb_gnt)
    );

    // Grant is forced off while reset is asserted so nothing reaches memory.
    always_comb begin
        gnt = 2'b00;
        case (state)
            IDLE:    gnt = arb_gnt;
            OWN0:    gnt = {1'b0, req0_valid};
            OWN1:    gnt = {req1_valid, 1'b0};
            default: gnt = 2'b00;
        endcase
        if (rst)
            gnt = 2'b00;
    end

    assign beat       = |gnt;
    assign sel        = gnt[1];
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    assign b_we    = sel ? req1_we    : req0_we;
    assign b_uns   = sel ? req1_uns   : req0_uns;
    assign b_lock  = sel ? req1_lock  : req0_lock;
    assign b_size  = sel ? req1_size  : req0_size;
    assign b_addr  = sel ? req1_addr  : req0_addr;
    assign b_wdata = sel ? req1_wdata : req0_wdata;
    assign legal   = (b_size != SZ_BAD);

    always_comb begin
        mem_memi  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        if (beat) begin
            mem_memi[MEMI_UNS]              = b_uns;
            mem_memi[MEMI_SZ_HI:MEMI_SZ_LO] = b_size;
            mem_memi[MEMI_ST]               = b_we & legal;
            mem_memi[MEMI_LD]               = ~b_we & legal;
            mem_addr                        = b_addr;
            mem_wdata                       = b_wdata;
            mem_wren                        = b_we & legal;
        end
    end

    // Lock length counts accepted beats only; an idle owner never times out.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = lock_cnt;
        last_nxt  = last_grant;
        cnt_inc   = (state == IDLE) ? CNT_W'(1) : lock_cnt + CNT_W'(1);
        if (beat) begin
            last_nxt = sel;
            if (!b_lock || cnt_inc == CNT_W'(LOCK_MAX)) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else begin
                state_nxt = sel ? OWN1 : OWN0;
                cnt_nxt   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_nxt;
            lock_cnt   <= cnt_nxt;
            last_grant <= last_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_v  <= 2'b00;
            rsp_e  <= 2'b00;
            rsp_d0 <= '0;
            rsp_d1 <= '0;
        end else begin
            rsp_v <= 2'b00;
            rsp_e <= 2'b00;
            if (beat && (!b_we || !legal)) begin
                rsp_v[sel] <= 1'b1;
                rsp_e[sel] <= ~legal;
                if (sel)
                    rsp_d1 <= legal ? mem_rdata : 32'd0;
                else
                    rsp_d0 <= legal ? mem_rdata : 32'd0;
            end
        end
    end

    assign rsp0_valid = rsp_v[0];
    assign rsp1_valid = rsp_v[1];
    assign rsp0_err   = rsp_e[0];
    assign rsp1_err   = rsp_e[1];
    assign rsp0_rdata = rsp_d0;
    assign rsp1_rdata = rsp_d1;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small behavioural memory.
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_we, req0_uns, req0_lock;
    logic [1:0]  req0_size;
    logic [31:0] req0_addr, req0_wdata;
    logic        rsp0_valid, rsp0_err;
    logic [31:0] rsp0_rdata;
    logic        req1_valid, req1_ready, req1_we, req1_uns, req1_lock;
    logic [1:0]  req1_size;
    logic [31:0] req1_addr, req1_wdata;
    logic        rsp1_valid, rsp1_err;
    logic [31:0] rsp1_rdata;
    logic [4:0]  mem_memi;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wren;

    logic [31:0] mem [0:63];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_wren) mem[mem_addr[7:2]] <= mem_wdata;

    data_mem_arbiter #(.LOCK_MAX(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_size(req0_size), .req0_uns(req0_uns), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_size(req1_size), .req1_uns(req1_uns), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_memi(mem_memi), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req0_valid = 0; req0_we = 0; req0_size = 2'd2; req0_uns = 0; req0_lock = 0;
        req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_size = 2'd2; req1_uns = 0; req1_lock = 0;
        req1_addr = 0; req1_wdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEADBEEF;
        mem[8] = 32'h12345678;
        clear_reqs();
        rst = 1;
        req0_valid = 1; req0_we = 1; req0_addr = 32'h10;
        tick();
        check("rst_ready0", {31'd0, req0_ready}, 0);
        check("rst_wren", {31'd0, mem_wren}, 0);
        check("rst_memi_lo", {30'd0, mem_memi[1:0]}, 0);
        check("rst_rsp0_valid", {31'd0, rsp0_valid}, 0);
        check("rst_rsp0_rdata", rsp0_rdata, 0);
        tick();
        rst = 0;
        clear_reqs();

        // 1: single port-0 word load
        req0_valid = 1; req0_addr = 32'h10; req0_size = 2'd2;
        #1;
        check("t1_ready0", {31'd0, req0_ready}, 1);
        check("t1_memi", {27'd0, mem_memi}, 32'b01001);
        check("t1_addr", mem_addr, 32'h10);
        tick();
        req0_valid = 0;
        #1;
        check("t1_rsp_valid", {31'd0, rsp0_valid}, 1);
        check("t1_rsp_rdata", rsp0_rdata, 32'hDEADBEEF);
        check("t1_rsp_err", {31'd0, rsp0_err}, 0);
        tick();
        check("t1_rsp_pulse", {31'd0, rsp0_valid}, 0);

        // 2: alternating grant after reset
        do_reset();
        req0_valid = 1; req0_addr = 32'h10;
        req1_valid = 1; req1_addr = 32'h20;
        #1;
        check("t2_c0_ready0", {31'd0, req0_ready}, 1);
        check("t2_c0_ready1", {31'd0, req1_ready}, 0);
        tick();
        check("t2_c1_ready1", {31'd0, req1_ready}, 1);
        check("t2_c1_ready0", {31'd0, req0_ready}, 0);
        check("t2_c1_rsp0", rsp0_rdata, 32'hDEADBEEF);
        check("t2_c1_rsp1v", {31'd0, rsp1_valid}, 0);
        tick();
        check("t2_c2_ready0", {31'd0, req0_ready}, 1);
        check("t2_c2_rsp1v", {31'd0, rsp1_valid}, 1);
        check("t2_c2_rsp1", rsp1_rdata, 32'h12345678);
        tick();

        // 3: port-1 locked burst of four stores, port 0 waiting
        req1_we = 1; req1_lock = 1; req1_addr = 32'h40; req1_wdata = 32'hA0;
        #1;
        check("t3_b0_rsp0v", {31'd0, rsp0_valid}, 1);
        check("t3_b0_memi", {27'd0, mem_memi}, 32'b01010);
        check("t3_b0_wren", {31'd0, mem_wren}, 1);
        for (int b = 0; b < 4; b++) begin
            req1_addr = 32'h40 + 4 * b;
            req1_wdata = 32'hA0 + b;
            req1_lock = (b < 3);
            #1;
            check("t3_ready0_low", {31'd0, req0_ready}, 0);
            check("t3_ready1_high", {31'd0, req1_ready}, 1);
            tick();
        end
        req1_valid = 0; req1_we = 0; req1_lock = 0;
        #1;
        check("t3_c5_ready0", {31'd0, req0_ready}, 1);
        check("t3_c5_rsp1v", {31'd0, rsp1_valid}, 0);
        check("t3_mem16", mem[16], 32'hA0);
        check("t3_mem19", mem[19], 32'hA3);
        tick();

        // 4: port 1 holds lock indefinitely; forced release after 16 beats
        req1_valid = 1; req1_lock = 1; req1_addr = 32'h20;
        #1;
        check("t4_rsp0v", {31'd0, rsp0_valid}, 1);
        for (int b = 0; b < 16; b++) begin
            check("t4_ready1", {31'd0, req1_ready}, 1);
            check("t4_ready0", {31'd0, req0_ready}, 0);
            tick();
        end
        check("t4_release_ready0", {31'd0, req0_ready}, 1);
        check("t4_release_ready1", {31'd0, req1_ready}, 0);
        check("t4_rsp1v", {31'd0, rsp1_valid}, 1);
        tick();

        // 6: reset while port 1 owns the memory with a load in flight
        check("t6_ready1", {31'd0, req1_ready}, 1);
        #2;
        rst = 1;
        #1;
        check("t6_rst_ready1", {31'd0, req1_ready}, 0);
        tick();
        check("t6_rsp1v", {31'd0, rsp1_valid}, 0);
        check("t6_rsp1_rdata", rsp1_rdata, 0);
        rst = 0;
        req1_lock = 0;
        #1;
        check("t6_tie_ready0", {31'd0, req0_ready}, 1);
        check("t6_tie_ready1", {31'd0, req1_ready}, 0);
        clear_reqs();
        tick();

        // 5: byte store encoding, then illegal size
        do_reset();
        req0_valid = 1; req0_we = 1; req0_size = 2'd0; req0_uns = 0;
        req0_addr = 32'h30; req0_wdata = 32'h80;
        #1;
        check("t5_memi", {27'd0, mem_memi}, 32'b00010);
        check("t5_wren", {31'd0, mem_wren}, 1);
        tick();
        check("t5_store_norsp", {31'd0, rsp0_valid}, 0);
        req0_size = 2'd3;
        #1;
        check("t5_bad_ready", {31'd0, req0_ready}, 1);
        check("t5_bad_wren", {31'd0, mem_wren}, 0);
        check("t5_bad_memi_lo", {30'd0, mem_memi[1:0]}, 0);
        tick();
        req0_valid = 0;
        #1;
        check("t5_err_valid", {31'd0, rsp0_valid}, 1);
        check("t5_err", {31'd0, rsp0_err}, 1);
        check("t5_err_rdata", rsp0_rdata, 0);
        check("t5_mem12", mem[12], 32'h80);
        tick();
        check("t5_err_pulse", {31'd0, rsp0_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
